// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the 5-stage ARM core.
// It captures decoded control, operands and shift/immediate fields, and supports freeze (hold) and flush (bubble).
module id_exe_stage_reg #(
   parameter int REGISTER_LEN = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    freeze,
   input  logic                    wb_en_in,
   input  logic                    mem_r_en_in,
   input  logic                    mem_w_en_in,
   input  logic                    b_in,
   input  logic                    s_in,
   input  logic                    immd_in,
   input  logic [3:0]              exe_cmd_in,
   input  logic [REGISTER_LEN-1:0] pc_in,
   input  logic [REGISTER_LEN-1:0] val_rn_in,
   input  logic [REGISTER_LEN-1:0] val_rm_in,
   input  logic [11:0]             shift_operand_in,
   input  logic [23:0]             signed_imm_24_in,
   input  logic [3:0]              dest_in,
   input  logic [3:0]              src1_in,
   input  logic [3:0]              src2_in,
   input  logic [3:0]              status_in,
   input  logic                    valid_in,
   output logic                    wb_en_out,
   output logic                    mem_r_en_out,
   output logic                    mem_w_en_out,
   output logic                    b_out,
   output logic                    s_out,
   output logic                    immd_out,
   output logic [3:0]              exe_cmd_out,
   output logic [REGISTER_LEN-1:0] pc_out,
   output logic [REGISTER_LEN-1:0] val_rn_out,
   output logic [REGISTER_LEN-1:0] val_rm_out,
   output logic [11:0]             shift_operand_out,
   output logic [23:0]             signed_imm_24_out,
   output logic [3:0]              dest_out,
   output logic [3:0]              src1_out,
   output logic [3:0]              src2_out,
   output logic [3:0]              status_out,
   output logic                    valid_out,
   output logic                    is_mem_command_out
);

   // Flush takes priority over freeze. A bubble is an all-zero word, so it never writes back, touches memory or branches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         wb_en_out         <= 1'b0;
         mem_r_en_out      <= 1'b0;
         mem_w_en_out      <= 1'b0;
         b_out             <= 1'b0;
         s_out             <= 1'b0;
         immd_out          <= 1'b0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         shift_operand_out <= '0;
         signed_imm_24_out <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
         status_out        <= '0;
         valid_out         <= 1'b0;
      end else if (!freeze) begin
         wb_en_out         <= wb_en_in;
         mem_r_en_out      <= mem_r_en_in;
         mem_w_en_out      <= mem_w_en_in;
         b_out             <= b_in;
         s_out             <= s_in;
         immd_out          <= immd_in;
         exe_cmd_out       <= exe_cmd_in;
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         shift_operand_out <= shift_operand_in;
         signed_imm_24_out <= signed_imm_24_in;
         dest_out          <= dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
         status_out        <= status_in;
         valid_out         <= valid_in;
      end
   end

   assign is_mem_command_out = mem_r_en_out | mem_w_en_out;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed testbench for id_exe_stage_reg.
// It covers reset, load, the memory-command flag, freeze, flush-over-freeze and asynchronous reset.
module tb_id_exe_stage_reg;

   logic        clk = 1'b0;
   logic        rst, flush, freeze;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, immd_in, valid_in;
   logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, status_in;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_24_in;

   logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, immd_out, valid_out;
   logic        is_mem_command_out;
   logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;

   int checks = 0;
   int errors = 0;

   id_exe_stage_reg #(.REGISTER_LEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .immd_in(immd_in), .exe_cmd_in(exe_cmd_in),
      .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
      .status_in(status_in), .valid_in(valid_in),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .b_out(b_out), .s_out(s_out), .immd_out(immd_out), .exe_cmd_out(exe_cmd_out),
      .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
      .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
      .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
      .status_out(status_out), .valid_out(valid_out),
      .is_mem_command_out(is_mem_command_out)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] pc, input logic [3:0] dest, input logic wb, input logic valid);
      pc_in    = pc;
      dest_in  = dest;
      wb_en_in = wb;
      valid_in = valid;
   endtask

   task automatic clear_inputs();
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, immd_in, valid_in} = '0;
      {exe_cmd_in, dest_in, src1_in, src2_in, status_in} = '0;
      {pc_in, val_rn_in, val_rm_in} = '0;
      shift_operand_in = '0;
      signed_imm_24_in = '0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset with every input driven high.
      rst = 1'b0; flush = 1'b1; freeze = 1'b1;
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, immd_in, valid_in} = '1;
      {exe_cmd_in, dest_in, src1_in, src2_in, status_in} = '1;
      {val_rn_in, val_rm_in} = '1;
      shift_operand_in = '1;
      signed_imm_24_in = '1;
      pc_in = 32'h0000_0040;
      #1 rst = 1'b1;
      #1;
      check_output("reset_pc", pc_out, 32'h0);
      check_output("reset_valid", {31'b0, valid_out}, 32'h0);
      check_output("reset_status", {28'b0, status_out}, 32'h0);
      check_output("reset_is_mem", {31'b0, is_mem_command_out}, 32'h0);
      flush = 1'b0; freeze = 1'b0;
      step();
      step();
      check_output("reset_hold_pc", pc_out, 32'h0);
      check_output("reset_hold_wb", {31'b0, wb_en_out}, 32'h0);
      check_output("reset_hold_val_rm", val_rm_out, 32'h0);

      // Plain load: all fields pass through with one cycle of latency.
      rst = 1'b0;
      clear_inputs();
      apply_stimulus(32'h0000_0008, 4'd3, 1'b1, 1'b1);
      val_rm_in = 32'h8000_0001; shift_operand_in = 12'h0E3; exe_cmd_in = 4'h1;
      val_rn_in = 32'h1234_5678; signed_imm_24_in = 24'hABCDEF;
      src1_in = 4'd1; src2_in = 4'd2; status_in = 4'hA; b_in = 1'b1; s_in = 1'b1;
      step();
      check_output("load_pc", pc_out, 32'h0000_0008);
      check_output("load_val_rm", val_rm_out, 32'h8000_0001);
      check_output("load_shift", {20'b0, shift_operand_out}, 32'h0E3);
      check_output("load_immd", {31'b0, immd_out}, 32'h0);
      check_output("load_exe_cmd", {28'b0, exe_cmd_out}, 32'h1);
      check_output("load_wb", {31'b0, wb_en_out}, 32'h1);
      check_output("load_valid", {31'b0, valid_out}, 32'h1);
      check_output("load_is_mem", {31'b0, is_mem_command_out}, 32'h0);
      check_output("load_val_rn", val_rn_out, 32'h1234_5678);
      check_output("load_imm24", {8'b0, signed_imm_24_out}, 32'h00AB_CDEF);
      check_output("load_regs", {20'b0, dest_out, src1_out, src2_out}, 32'h312);
      check_output("load_status", {28'b0, status_out}, 32'hA);
      check_output("load_b_s", {30'b0, b_out, s_out}, 32'h3);

      // Inputs that change between edges must not reach the outputs.
      pc_in = 32'hDEAD_BEEF;
      #1;
      check_output("no_comb_path_pc", pc_out, 32'h0000_0008);

      // Memory command flag tracks read, then write.
      mem_r_en_in = 1'b1;
      step();
      check_output("mem_r_out", {30'b0, mem_r_en_out, mem_w_en_out}, 32'h2);
      check_output("mem_r_is_mem", {31'b0, is_mem_command_out}, 32'h1);
      mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
      step();
      check_output("mem_w_out", {30'b0, mem_r_en_out, mem_w_en_out}, 32'h1);
      check_output("mem_w_is_mem", {31'b0, is_mem_command_out}, 32'h1);
      mem_w_en_in = 1'b0;
      step();
      check_output("mem_none_is_mem", {31'b0, is_mem_command_out}, 32'h0);

      // Freeze holds instruction A for three edges while B is presented.
      apply_stimulus(32'h0000_0100, 4'd3, 1'b1, 1'b1);
      step();
      check_output("freeze_load_a", {28'b0, dest_out}, 32'd3);
      freeze = 1'b1;
      apply_stimulus(32'h0000_0200, 4'd5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output($sformatf("freeze_dest_%0d", i), {28'b0, dest_out}, 32'd3);
         check_output($sformatf("freeze_pc_%0d", i), pc_out, 32'h0000_0100);
         check_output($sformatf("freeze_valid_%0d", i), {31'b0, valid_out}, 32'h1);
      end
      freeze = 1'b0;
      step();
      check_output("unfreeze_dest", {28'b0, dest_out}, 32'd5);
      check_output("unfreeze_pc", pc_out, 32'h0000_0200);

      // Flush wins over freeze and yields an all-zero bubble.
      apply_stimulus(32'h0000_0300, 4'd3, 1'b1, 1'b1);
      step();
      check_output("pre_flush_wb", {31'b0, wb_en_out}, 32'h1);
      flush = 1'b1; freeze = 1'b1;
      step();
      check_output("flush_pc", pc_out, 32'h0);
      check_output("flush_wb_valid", {30'b0, wb_en_out, valid_out}, 32'h0);
      check_output("flush_dest", {28'b0, dest_out}, 32'h0);
      check_output("flush_val_rm", val_rm_out, 32'h0);
      check_output("flush_status", {28'b0, status_out}, 32'h0);
      flush = 1'b0; freeze = 1'b0;
      step();
      check_output("post_flush_pc", pc_out, 32'h0000_0300);
      check_output("post_flush_valid", {31'b0, valid_out}, 32'h1);

      // Asynchronous reset between edges clears the outputs immediately.
      #2 rst = 1'b1;
      #1;
      check_output("async_rst_pc", pc_out, 32'h0);
      check_output("async_rst_valid", {31'b0, valid_out}, 32'h0);
      check_output("async_rst_val_rm", val_rm_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_output("after_rst_load_pc", pc_out, 32'h0000_0300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the Instruction Decode stage and the Execute stage of the 5-stage ARM core.
- Captures decoded control, operand values and shift/immediate fields on every clock.
- Feeds the EXE stage: Rm value, shift operand, immediate flag and memory-command flag go to the Val2 generator; the remaining fields go to the ALU, the branch adder and the EXE/MEM register.
- Supports hazard freeze (hold) and branch flush (bubble insertion).

Parameters:
- REGISTER_LEN, 32, datapath width for PC and register operand values.

Ports:
- clk  input  1  core clock; all updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  branch taken in EXE; insert bubble.
- freeze  input  1  hazard unit stall; hold current contents.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, immd_in  input  1 each  decoded control bits.
- exe_cmd_in  input  4  ALU command.
- pc_in  input  REGISTER_LEN  PC+4 of the decoded instruction.
- val_rn_in, val_rm_in  input  REGISTER_LEN  register-file read values.
- shift_operand_in  input  12  instruction bits [11:0].
- signed_imm_24_in  input  24  branch offset.
- dest_in, src1_in, src2_in  input  4 each  register indices.
- status_in  input  4  NZCV flags at decode.
- valid_in  input  1  ID holds a real instruction.
- The same fields as outputs, each with suffix _out and the same width.
- is_mem_command_out  output  1  mem_r_en_out OR mem_w_en_out.

Behaviour:
- Reset: while rst = 1 and asynchronously on its assertion, every registered output is 0.
  - This includes valid_out, status_out and pc_out.
  - is_mem_command_out is therefore 0.
- Priority at each rising clk edge, rst deasserted: flush > freeze > load.
- Load (flush = 0, freeze = 0): every *_out takes its *_in value.
  - Latency is exactly one cycle.
  - No field is transformed; widths pass through unchanged.
- Freeze (flush = 0, freeze = 1): all outputs hold their previous values, including valid_out.
- Flush (flush = 1, regardless of freeze): all outputs are cleared to 0, producing a bubble.
  - A bubble has no writeback, no memory access, no branch, no flag update, and valid_out = 0.
  - The EXE/MEM register and the Val2 path see all-zero operands.
- is_mem_command_out is combinational from the registered mem_r_en_out and mem_w_en_out. It has no extra latency.
- Inputs are sampled only at the edge; input changes between edges have no effect.
- Reset asserted mid-freeze or mid-flush: reset wins immediately. After deassertion the first edge behaves per the priority rules.
- Consecutive freeze cycles hold indefinitely. The first non-frozen edge loads the then-current inputs.
- flush and freeze both high on the same edge: treated as flush.
- No combinational path exists from any *_in to any *_out.

Test Plan:
- Reset: assert rst with all inputs at 1s and pc_in = 0x0000_0040 -> all outputs 0 before any clk edge; they stay 0 while rst is high.
- Load: rst low, pc_in = 0x0000_0008, val_rm_in = 0x8000_0001, shift_operand_in = 0x0E3, immd_in = 0, exe_cmd_in = 0x1, wb_en_in = 1, valid_in = 1 -> the same values appear on the outputs one edge later; is_mem_command_out = 0.
- Memory command: mem_r_en_in = 1, then mem_w_en_in = 1 on the next edge -> is_mem_command_out = 1 on both following cycles. mem_r_en_out and mem_w_en_out track with one-cycle latency.
- Freeze: load instruction A (dest = 3), raise freeze for 3 cycles while presenting B (dest = 5) -> outputs remain A for 3 cycles. The first edge after freeze drops loads B.
- Flush over freeze: outputs hold A with wb_en_out = 1, then flush = 1 and freeze = 1 on the same edge -> all outputs 0 including valid_out and wb_en_out. The next load edge restores normal capture.
- Async reset mid-stream: assert rst between clock edges while outputs hold nonzero data -> outputs go to 0 without waiting for clk.
